fifo2ddr_wr_burst_mc: RTL

- Multi-channel successor to the single-channel FIFO-to-DDR write burst engine. Runs entirely in the ddr_clk domain.
- Monitors CH_NUM width-converting async FIFO read sides (the FIFOs themselves are external) and round-robin arbitrates full bursts onto one DDR write-burst port.
- Each channel owns a ring-buffer region with runtime base and size. Partial data is flushed after an idle timeout.
- Raises a per-channel interrupt every cfg_irq_size blocks written (1 block = DDR_DATA_WD bits).

---
 rtl/fifo2ddr_wr_burst_mc.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fifo2ddr_wr_burst_mc.sv
// ---------------------------------------------------------------------------
// fifo2ddr_wr_burst_mc
//
// Purpose:
//   Multi-channel FIFO-to-DDR write burst engine. It watches CH_NUM external
//   FWFT FIFO read sides and arbitrates their bursts round-robin onto a single
//   DDR write-burst port. Each channel writes into its own ring region
//   (runtime base and size). A channel is served with a full burst when it
//   holds at least BURST_LEN blocks. Smaller leftovers are flushed once the
//   channel's occupancy has been static for FLUSH_TO cycles. Each channel
//   raises a sticky interrupt every cfg_irq_size blocks written.
//
// Ports:
//   ddr_clk, ddr_rst_n       clock, asynchronous active-low reset
//   cfg_rst                  synchronous soft reset of all channel state
//   cfg_base_addr            per-channel region base address
//   cfg_max_blk              per-channel region size in blocks
//   cfg_irq_size             blocks per interrupt (shared by all channels)
//   ch_rd_cnt/ch_empty/ch_dout  FIFO read-side status and FWFT data
//   ch_rd                    FIFO read strobes (one-hot on the granted channel)
//   wr_burst_*               DDR write-burst port
//   blk_cnt                  per-channel write pointer in blocks
//   irq_pend/irq_clr         per-channel interrupt pending and clear
// ---------------------------------------------------------------------------
module fifo2ddr_wr_burst_mc #(
  parameter int CH_NUM       = 4,
  parameter int FIFO_ADDR_WD = 11,
  parameter int DDR_ADDR_WD  = 32,
  parameter int DDR_DATA_WD  = 512,
  parameter int BURST_LEN    = 16,
  parameter int ADDR_SHIFT   = 3,
  parameter int FLUSH_TO     = 1024
) (
  input  logic                                   ddr_clk,
  input  logic                                   ddr_rst_n,
  input  logic                                   cfg_rst,
  input  logic [CH_NUM*DDR_ADDR_WD-1:0]          cfg_base_addr,
  input  logic [CH_NUM*32-1:0]                   cfg_max_blk,
  input  logic [31:0]                            cfg_irq_size,
  input  logic [CH_NUM*(FIFO_ADDR_WD+1)-1:0]     ch_rd_cnt,
  input  logic [CH_NUM-1:0]                      ch_empty,
  input  logic [CH_NUM*DDR_DATA_WD-1:0]          ch_dout,
  output logic [CH_NUM-1:0]                      ch_rd,
  output logic                                   wr_burst_req,
  output logic [9:0]                             wr_burst_len,
  output logic [DDR_ADDR_WD-1:0]                 wr_burst_addr,
  input  logic                                   wr_burst_data_req,
  output logic [DDR_DATA_WD-1:0]                 wr_burst_data,
  input  logic                                   wr_burst_finish,
  output logic [CH_NUM*32-1:0]                   blk_cnt,
  output logic [CH_NUM-1:0]                      irq_pend,
  input  logic [CH_NUM-1:0]                      irq_clr
);

  localparam int RATE   = DDR_DATA_WD / 128;
  localparam int CNT_WD = FIFO_ADDR_WD + 1;
  localparam int CH_WD  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int TMR_WD = (FLUSH_TO > 0) ? $clog2(FLUSH_TO + 1) : 1;

  localparam logic [CNT_WD-1:0] BURST_CNT   = CNT_WD'(BURST_LEN);
  localparam logic [TMR_WD-1:0] TMR_MAX     = TMR_WD'(FLUSH_TO);
  localparam logic [9:0]        BURST_LEN10 = 10'(BURST_LEN);
  localparam logic [CH_WD-1:0]  LAST_CH     = CH_WD'(CH_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_REQ,
    ST_DATA,
    ST_WAIT_FIN
  } state_t;

  state_t                 state_reg;
  logic [CH_WD-1:0]       gnt_reg;
  logic [CH_WD-1:0]       rr_reg;
  logic [9:0]             len_reg;
  logic [9:0]             beat_reg;
  logic [DDR_ADDR_WD-1:0] addr_reg;
  logic                   req_reg;

  // Unpacked per-channel views of the flattened ports
  logic [CNT_WD-1:0]      rd_cnt_arr  [CH_NUM];
  logic [DDR_ADDR_WD-1:0] base_arr    [CH_NUM];
  logic [31:0]            max_arr     [CH_NUM];
  logic [DDR_DATA_WD-1:0] dout_arr    [CH_NUM];
  logic [31:0]            blk_cnt_arr [CH_NUM];

  logic [CH_NUM-1:0]      full_vec;
  logic [CH_NUM-1:0]      flush_vec;
  logic [CH_NUM-1:0]      elig_vec;
  logic [CH_NUM-1:0]      gnt_hit;
  logic [CH_NUM-1:0]      fin_hit;

  logic                   arb_found;
  logic [CH_WD-1:0]       arb_sel;
  logic [31:0]            sel_room;
  logic [31:0]            sel_cnt32;
  logic [9:0]             flush_len;
  logic [DDR_ADDR_WD-1:0] arb_addr;
  logic [DDR_DATA_WD-1:0] dout_sel;

  genvar gi;

  // -------------------------------------------------------------------------
  // Per-channel state: idle timer, ring pointer, interrupt accumulator
  // -------------------------------------------------------------------------
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [CNT_WD-1:0] prev_cnt_reg;
      logic [TMR_WD-1:0] tmr_reg;
      logic [31:0]       blk_reg;
      logic [31:0]       irq_acc_reg;
      logic              pend_reg;
      logic [32:0]       blk_sum;
      logic              blk_wrap;
      logic [32:0]       irq_sum;
      logic              irq_hit;
      logic              irq_set;

      assign rd_cnt_arr[gi]  = ch_rd_cnt[gi*CNT_WD +: CNT_WD];
      assign base_arr[gi]    = cfg_base_addr[gi*DDR_ADDR_WD +: DDR_ADDR_WD];
      assign max_arr[gi]     = cfg_max_blk[gi*32 +: 32];
      assign dout_arr[gi]    = ch_dout[gi*DDR_DATA_WD +: DDR_DATA_WD];
      assign blk_cnt_arr[gi] = blk_reg;
      assign blk_cnt[gi*32 +: 32] = blk_reg;
      assign irq_pend[gi]    = pend_reg;

      assign full_vec[gi]  = !ch_empty[gi] && (rd_cnt_arr[gi] >= BURST_CNT);
      // A leftover below one burst only goes out once the FIFO has been quiet
      // for the full timeout; a zero timeout switches flushing off.
      assign flush_vec[gi] = (FLUSH_TO > 0) && (rd_cnt_arr[gi] != '0) &&
                             (rd_cnt_arr[gi] < BURST_CNT) && (tmr_reg == TMR_MAX);
      assign elig_vec[gi]  = full_vec[gi] | flush_vec[gi];

      assign gnt_hit[gi] = (state_reg == ST_ARB) && arb_found && (arb_sel == CH_WD'(gi));
      assign fin_hit[gi] = (state_reg == ST_WAIT_FIN) && wr_burst_finish &&
                           (gnt_reg == CH_WD'(gi));

      // 33-bit sums so the wrap / interrupt compares never overflow
      assign blk_sum  = {1'b0, blk_reg} + {23'd0, len_reg};
      assign blk_wrap = blk_sum >= {1'b0, max_arr[gi]};
      assign irq_sum  = {1'b0, irq_acc_reg} + {23'd0, len_reg};
      assign irq_hit  = irq_sum >= {1'b0, cfg_irq_size};
      assign irq_set  = fin_hit[gi] && irq_hit;

      always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
        if (!ddr_rst_n) begin
          prev_cnt_reg <= '0;
          tmr_reg      <= '0;
          blk_reg      <= '0;
          irq_acc_reg  <= '0;
          pend_reg     <= 1'b0;
        end else if (cfg_rst) begin
          prev_cnt_reg <= '0;
          tmr_reg      <= '0;
          blk_reg      <= '0;
          irq_acc_reg  <= '0;
          pend_reg     <= 1'b0;
        end else begin
          prev_cnt_reg <= rd_cnt_arr[gi];
          if ((rd_cnt_arr[gi] != prev_cnt_reg) || gnt_hit[gi]) begin
            tmr_reg <= '0;
          end else if (tmr_reg != TMR_MAX) begin
            tmr_reg <= tmr_reg + 1'b1;
          end

          if (fin_hit[gi]) begin
            blk_reg     <= blk_wrap ? '0 : blk_sum[31:0];
            irq_acc_reg <= irq_hit ? 32'(irq_sum - {1'b0, cfg_irq_size}) : irq_sum[31:0];
          end

          // A new interrupt in the same cycle as a clear must not be lost
          if (irq_set) begin
            pend_reg <= 1'b1;
          end else if (irq_clr[gi]) begin
            pend_reg <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin search: first eligible channel at or above the RR pointer
  // -------------------------------------------------------------------------
  always_comb begin
    int j;
    j         = 0;
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      j = (int'(rr_reg) + k) % CH_NUM;
      if (!arb_found && elig_vec[j]) begin
        arb_found = 1'b1;
        arb_sel   = CH_WD'(j);
      end
    end
  end

  // A flush never runs past the end of the region; the next burst wraps.
  assign sel_room  = max_arr[arb_sel] - blk_cnt_arr[arb_sel];
  assign sel_cnt32 = 32'(rd_cnt_arr[arb_sel]);
  assign flush_len = (sel_cnt32 <= sel_room) ? 10'(sel_cnt32) : 10'(sel_room);
  assign arb_addr  = base_arr[arb_sel] + (DDR_ADDR_WD'(blk_cnt_arr[arb_sel]) << ADDR_SHIFT);

  // -------------------------------------------------------------------------
  // Burst FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge ddr_clk or negedge ddr_rst_n) begin
    if (!ddr_rst_n) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= '0;
      rr_reg    <= '0;
      len_reg   <= '0;
      beat_reg  <= '0;
      addr_reg  <= '0;
      req_reg   <= 1'b0;
    end else if (cfg_rst) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= '0;
      rr_reg    <= '0;
      len_reg   <= '0;
      beat_reg  <= '0;
      addr_reg  <= '0;
      req_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|elig_vec) begin
            state_reg <= ST_ARB;
          end
        end

        ST_ARB: begin
          if (arb_found) begin
            gnt_reg   <= arb_sel;
            len_reg   <= full_vec[arb_sel] ? BURST_LEN10 : flush_len;
            addr_reg  <= arb_addr;
            rr_reg    <= (arb_sel == LAST_CH) ? '0 : arb_sel + 1'b1;
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end else begin
            // Eligibility vanished between IDLE and ARB
            state_reg <= ST_IDLE;
          end
        end

        ST_REQ: begin
          // The first data request is already a beat, so it is counted here
          if (wr_burst_data_req) begin
            req_reg   <= 1'b0;
            beat_reg  <= 10'd1;
            state_reg <= (len_reg == 10'd1) ? ST_WAIT_FIN : ST_DATA;
          end
        end

        ST_DATA: begin
          if (wr_burst_data_req) begin
            beat_reg <= beat_reg + 10'd1;
            if ((beat_reg + 10'd1) == len_reg) begin
              state_reg <= ST_WAIT_FIN;
            end
          end
        end

        ST_WAIT_FIN: begin
          if (wr_burst_finish) begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign wr_burst_req  = req_reg;
  assign wr_burst_len  = len_reg;
  assign wr_burst_addr = addr_reg;

  // FWFT: the read strobe follows the controller's pull in the same cycle
  always_comb begin
    ch_rd = '0;
    if (!cfg_rst && wr_burst_data_req &&
        ((state_reg == ST_REQ) || (state_reg == ST_DATA))) begin
      ch_rd[gnt_reg] = 1'b1;
    end
  end

  // 128-bit word order is reversed within each beat
  assign dout_sel = dout_arr[gnt_reg];
  generate
    for (gi = 0; gi < RATE; gi++) begin : g_swap
      assign wr_burst_data[gi*128 +: 128] = dout_sel[(RATE-1-gi)*128 +: 128];
    end
  endgenerate

endmodule
